// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline registers.
// mem_ctrl_t is the control bundle carried from EX into MEM (and reusable in MEM/WB).
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic valid;
        logic wreg;
        logic m2reg;
        logic wmem;
        logic beq;
        logic bne;
        logic z;
    } mem_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop: sync active-low reset, enable, and a clear that loads zero.
// Priority is reset, then enable (hold when low), then clear, then load.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value when enabled: zero on a clear, otherwise the input.
    always_comb begin
        q_d = clr_i ? '0 : d_i;
    end

    // State register; a disabled cycle keeps the current value.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the five-stage MIPS core.
// Holds the control bundle, ALU result / store data and destination register,
// plus the registered load->store dependence select and a saturating bubble counter.
module ex_mem_reg #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hold,
    input  logic              flush,
    input  logic              e_valid,
    input  logic              e_wreg,
    input  logic              e_m2reg,
    input  logic              e_wmem,
    input  logic              e_beq,
    input  logic              e_bne,
    input  logic              e_z,
    input  logic [WIDTH-1:0]  e_alu,
    input  logic [WIDTH-1:0]  e_b,
    input  logic [REG_AW-1:0] e_rn,
    input  logic [REG_AW-1:0] e_rt,
    output logic              m_valid,
    output logic              m_wreg,
    output logic              m_m2reg,
    output logic              m_wmem,
    output logic              m_beq,
    output logic              m_bne,
    output logic              m_z,
    output logic [WIDTH-1:0]  m_alu,
    output logic [WIDTH-1:0]  m_b,
    output logic [REG_AW-1:0] m_rn,
    output logic              m_ldst_depen,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import mips_pkg::*;

    mem_ctrl_t          ctrl_d;
    mem_ctrl_t          ctrl_q;
    logic [2*WIDTH-1:0] data_q;
    logic [REG_AW-1:0]  rn_q;
    logic               depen_d;
    logic               depen_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Control bits of an invalid EX slot are squashed to zero before capture.
    always_comb begin
        ctrl_d = '0;
        if (e_valid) begin
            ctrl_d.valid = 1'b1;
            ctrl_d.wreg  = e_wreg;
            ctrl_d.m2reg = e_m2reg;
            ctrl_d.wmem  = e_wmem;
            ctrl_d.beq   = e_beq;
            ctrl_d.bne   = e_bne;
            ctrl_d.z     = e_z;
        end
    end

    pipe_reg #(.W($bits(mem_ctrl_t))) u_ctrl (
        .clk_i  (clk),
        .rstn_i (resetn),
        .en_i   (!hold),
        .clr_i  (flush),
        .d_i    (ctrl_d),
        .q_o    (ctrl_q)
    );

    pipe_reg #(.W(2*WIDTH)) u_data (
        .clk_i  (clk),
        .rstn_i (resetn),
        .en_i   (!hold),
        .clr_i  (flush),
        .d_i    ({e_alu, e_b}),
        .q_o    (data_q)
    );

    pipe_reg #(.W(REG_AW)) u_rn (
        .clk_i  (clk),
        .rstn_i (resetn),
        .en_i   (!hold),
        .clr_i  (flush),
        .d_i    (e_rn),
        .q_o    (rn_q)
    );

    // A store in EX depends on the load now in MEM (moving to WB) when it reads
    // that load's destination; register 0 never carries a dependence.
    always_comb begin
        depen_d = e_valid && e_wmem &&
                  ctrl_q.valid && ctrl_q.m2reg && ctrl_q.wreg &&
                  (rn_q == e_rt) && (rn_q != REG_AW'(REG_ZERO));
    end

    // Dependence select register, following the same reset/hold/flush priority.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            depen_q <= 1'b0;
        end else if (!hold) begin
            depen_q <= flush ? 1'b0 : depen_d;
        end
    end

    // Saturating increment: stick at all ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Bubble counter advances only on cycles that actually insert a bubble.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= cnt_d;
        end
    end

    assign m_valid      = ctrl_q.valid;
    assign m_wreg       = ctrl_q.wreg;
    assign m_m2reg      = ctrl_q.m2reg;
    assign m_wmem       = ctrl_q.wmem;
    assign m_beq        = ctrl_q.beq;
    assign m_bne        = ctrl_q.bne;
    assign m_z          = ctrl_q.z;
    assign m_alu        = data_q[2*WIDTH-1:WIDTH];
    assign m_b          = data_q[WIDTH-1:0];
    assign m_rn         = rn_q;
    assign m_ldst_depen = depen_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: a behavioural model predicts the outputs
// each cycle, pushes them to a scoreboard queue, and they are popped and
// compared one edge later. Directed checks cover the listed scenarios.
module tb_ex_mem_reg;

    localparam int WIDTH  = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              resetn, hold, flush;
    logic              e_valid, e_wreg, e_m2reg, e_wmem, e_beq, e_bne, e_z;
    logic [WIDTH-1:0]  e_alu, e_b;
    logic [REG_AW-1:0] e_rn, e_rt;
    logic              m_valid, m_wreg, m_m2reg, m_wmem, m_beq, m_bne, m_z;
    logic [WIDTH-1:0]  m_alu, m_b;
    logic [REG_AW-1:0] m_rn;
    logic              m_ldst_depen;
    logic [CNT_W-1:0]  bubble_cnt;

    always #5 clk = ~clk;

    ex_mem_reg #(.WIDTH(WIDTH), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .hold         (hold),
        .flush        (flush),
        .e_valid      (e_valid),
        .e_wreg       (e_wreg),
        .e_m2reg      (e_m2reg),
        .e_wmem       (e_wmem),
        .e_beq        (e_beq),
        .e_bne        (e_bne),
        .e_z          (e_z),
        .e_alu        (e_alu),
        .e_b          (e_b),
        .e_rn         (e_rn),
        .e_rt         (e_rt),
        .m_valid      (m_valid),
        .m_wreg       (m_wreg),
        .m_m2reg      (m_m2reg),
        .m_wmem       (m_wmem),
        .m_beq        (m_beq),
        .m_bne        (m_bne),
        .m_z          (m_z),
        .m_alu        (m_alu),
        .m_b          (m_b),
        .m_rn         (m_rn),
        .m_ldst_depen (m_ldst_depen),
        .bubble_cnt   (bubble_cnt)
    );

    typedef struct packed {
        logic              valid, wreg, m2reg, wmem, beq, bne, z;
        logic [WIDTH-1:0]  alu, b;
        logic [REG_AW-1:0] rn;
        logic              depen;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t mdl = '0;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge given the current inputs.
    task automatic model_next();
        exp_t n;
        n = mdl;
        if (!resetn) begin
            n = '0;
        end else if (hold) begin
            n = mdl;
        end else if (flush) begin
            n = '0;
            n.cnt = (mdl.cnt == {CNT_W{1'b1}}) ? mdl.cnt : CNT_W'(mdl.cnt + 1);
        end else begin
            n.valid = e_valid;
            n.wreg  = e_valid & e_wreg;
            n.m2reg = e_valid & e_m2reg;
            n.wmem  = e_valid & e_wmem;
            n.beq   = e_valid & e_beq;
            n.bne   = e_valid & e_bne;
            n.z     = e_valid & e_z;
            n.alu   = e_alu;
            n.b     = e_b;
            n.rn    = e_rn;
            n.depen = e_valid & e_wmem & mdl.valid & mdl.m2reg & mdl.wreg &
                      (mdl.rn == e_rt) & (mdl.rn != '0);
            n.cnt   = mdl.cnt;
        end
        mdl = n;
        sb_q.push_back(n);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'(1), 64'(0));
            return;
        end
        e = sb_q.pop_front();
        chk("m_valid", 64'(m_valid), 64'(e.valid));
        chk("m_wreg",  64'(m_wreg),  64'(e.wreg));
        chk("m_m2reg", 64'(m_m2reg), 64'(e.m2reg));
        chk("m_wmem",  64'(m_wmem),  64'(e.wmem));
        chk("m_beq",   64'(m_beq),   64'(e.beq));
        chk("m_bne",   64'(m_bne),   64'(e.bne));
        chk("m_z",     64'(m_z),     64'(e.z));
        chk("m_alu",   64'(m_alu),   64'(e.alu));
        chk("m_b",     64'(m_b),     64'(e.b));
        chk("m_rn",    64'(m_rn),    64'(e.rn));
        chk("m_depen", 64'(m_ldst_depen), 64'(e.depen));
        chk("bub_cnt", 64'(bubble_cnt),   64'(e.cnt));
    endtask

    // Inputs are changed 1 time unit after the rising edge, outputs sampled there too.
    task automatic cyc();
        model_next();
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic rand_ex();
        e_valid = 1'($urandom);
        e_wreg  = 1'($urandom);
        e_m2reg = 1'($urandom);
        e_wmem  = 1'($urandom);
        e_beq   = 1'($urandom);
        e_bne   = 1'($urandom);
        e_z     = 1'($urandom);
        e_alu   = $urandom;
        e_b     = $urandom;
        e_rn    = REG_AW'($urandom);
        e_rt    = REG_AW'($urandom);
    endtask

    task automatic set_ex(input logic v, input logic wr, input logic ld, input logic st,
                          input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] b,
                          input logic [REG_AW-1:0] rn, input logic [REG_AW-1:0] rt);
        e_valid = v;  e_wreg = wr; e_m2reg = ld; e_wmem = st;
        e_beq = 1'b0; e_bne = 1'b0; e_z = 1'b0;
        e_alu = alu;  e_b = b;     e_rn = rn;    e_rt = rt;
    endtask

    task automatic dep_case(input string tag, input logic [REG_AW-1:0] ld_rn,
                            input logic [REG_AW-1:0] st_rt, input logic exp_dep);
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, ld_rn, 5'd0);
        cyc();
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_00AA, 5'd0, st_rt);
        cyc();
        chk(tag, 64'(m_ldst_depen), 64'(exp_dep));
    endtask

    initial begin
        resetn = 1'b0; hold = 1'b0; flush = 1'b0;
        rand_ex();

        // Reset with random inputs; second cycle also has hold and flush high.
        cyc();
        rand_ex(); hold = 1'b1; flush = 1'b1;
        cyc();
        chk("rst_cnt",   64'(bubble_cnt), 64'(0));
        chk("rst_alu",   64'(m_alu),      64'(0));
        chk("rst_valid", 64'(m_valid),    64'(0));

        // Advance.
        resetn = 1'b1; hold = 1'b0; flush = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0007, 5'd5, 5'd0);
        cyc();
        chk("adv_alu",   64'(m_alu),   64'h10);
        chk("adv_b",     64'(m_b),     64'h7);
        chk("adv_rn",    64'(m_rn),    64'd5);
        chk("adv_wreg",  64'(m_wreg),  64'd1);
        chk("adv_valid", 64'(m_valid), 64'd1);

        // Invalid EX slot: control squashed, data still captured.
        e_valid = 1'b0; e_wreg = 1'b1; e_wmem = 1'b1; e_beq = 1'b1;
        e_alu = 32'hDEAD_BEEF; e_b = 32'h1234_5678; e_rn = 5'd17;
        cyc();
        chk("inv_wmem", 64'(m_wmem), 64'd0);
        chk("inv_alu",  64'(m_alu),  64'hDEAD_BEEF);
        chk("inv_rn",   64'(m_rn),   64'd17);

        // Load->store dependence cases.
        dep_case("dep_r8_r8", 5'd8, 5'd8, 1'b1);
        dep_case("dep_r8_r9", 5'd8, 5'd9, 1'b0);
        dep_case("dep_r0_r0", 5'd0, 5'd0, 1'b0);

        // Flush with a valid store in EX.
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0055, 5'd3, 5'd4);
        flush = 1'b1;
        cyc();
        chk("fl_wmem",  64'(m_wmem),     64'd0);
        chk("fl_valid", 64'(m_valid),    64'd0);
        chk("fl_alu",   64'(m_alu),      64'd0);
        chk("fl_cnt",   64'(bubble_cnt), 64'd1);

        // Hold beats flush for 3 cycles, then flush alone.
        flush = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0000_0DEF, 5'd12, 5'd0);
        cyc();
        hold = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            cyc();
            chk("hold_alu", 64'(m_alu),      64'h0ABC);
            chk("hold_rn",  64'(m_rn),       64'd12);
            chk("hold_cnt", 64'(bubble_cnt), 64'd1);
        end
        hold = 1'b0;
        cyc();
        chk("hf_valid", 64'(m_valid),    64'd0);
        chk("hf_alu",   64'(m_alu),      64'd0);
        chk("hf_cnt",   64'(bubble_cnt), 64'd2);

        // Reset asserted mid-hold wins.
        flush = 1'b0; hold = 1'b1; resetn = 1'b0;
        cyc();
        chk("rsthold_cnt", 64'(bubble_cnt), 64'd0);
        resetn = 1'b1; hold = 1'b0;

        // Saturation: 20 flushes with a 4-bit counter, then two more.
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_ex();
            cyc();
        end
        chk("sat_cnt", 64'(bubble_cnt), 64'd15);
        cyc();
        cyc();
        chk("sat_stay", 64'(bubble_cnt), 64'd15);

        // Reset the counter, then mixed random traffic against the model.
        resetn = 1'b0; flush = 1'b0;
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_ex();
            if ($urandom_range(0, 3) == 0) e_rt = e_rn;
            if ($urandom_range(0, 1) == 0) e_rt = mdl.rn;
            hold   = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            resetn = ($urandom_range(0, 60) != 0);
            cyc();
        end

        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register of the five-stage MIPS core. Sits between the execute stage and the memory stage. Captures the ALU result, store data, destination register and memory/branch control bits every cycle. Supports a back-end hold and a branch-taken flush that inserts a bubble. Also produces the registered load→store dependence select that the memory stage uses to choose between the EX store data and the write-back load result, plus a saturating bubble counter for debug.

## Interface
- `WIDTH`, default 32: datapath width.
- `REG_AW`, default 5: register-number width.
- `CNT_W`, default 16: bubble counter width.

- `clk` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `hold` in 1: freeze all state this cycle.
- `flush` in 1: memory-stage branch taken (btaken); load a bubble.
- `e_valid` in 1: EX holds a real instruction.
- `e_wreg` in 1: writes a register.
- `e_m2reg` in 1: is a load.
- `e_wmem` in 1: is a store.
- `e_beq`, `e_bne` in 1 each: branch kind.
- `e_z` in 1: ALU zero flag.
- `e_alu` in WIDTH: ALU result / memory address.
- `e_b` in WIDTH: store data from EX forwarding.
- `e_rn` in REG_AW: destination register.
- `e_rt` in REG_AW: store source register.
- `m_valid`, `m_wreg`, `m_m2reg`, `m_wmem`, `m_beq`, `m_bne`, `m_z` out 1 each: registered copies of the EX inputs.
- `m_alu`, `m_b` out WIDTH: registered copies of `e_alu` and `e_b`.
- `m_rn` out REG_AW: registered copy of `e_rn`.
- `m_ldst_depen` out 1: memory stage must store the write-back data instead of `m_b`.
- `bubble_cnt` out CNT_W: number of flush bubbles inserted.

## Operation
- Each cycle takes exactly one action. The action is chosen by priority, highest first:
  1. `!resetn`: every output register goes to 0, including `bubble_cnt`.
  2. `hold`: every register is unchanged. `flush` is ignored, because the branch raising it is still in MEM.
  3. `flush`: insert a bubble. All control outputs, `m_valid`, `m_ldst_depen`, `m_alu`, `m_b` and `m_rn` go to 0. `bubble_cnt` increments.
  4. Otherwise (advance): every `m_*` register takes its `e_*` input.
- Invalid EX input (`e_valid`=0) during an advance:
  - Control bits are stored as 0, regardless of their input values.
  - `m_alu`, `m_b` and `m_rn` still load their inputs.
- `m_ldst_depen` on an advance equals the AND of all of the following, evaluated on the current `m_*` values (the load about to move to WB):
  - `e_valid`, `e_wmem`
  - `m_valid`, `m_m2reg`, `m_wreg`
  - `m_rn == e_rt`
  - `m_rn != 0`
- Register 0 never causes a dependence.
- `bubble_cnt` saturates at all ones and does not wrap.

## Timing
- Latency: one cycle from an `e_*` input to its `m_*` output. No combinational path from any input to any output.
- All outputs read 0 in the first cycle after reset is released.
- If `hold` is asserted for N cycles, the outputs are stable for those N cycles. The next non-hold edge resumes with advance or flush.
- `flush` and `hold` asserted together: hold wins. If `flush` is still high in the next cycle that has no hold, the bubble is inserted then.
- Back-to-back flushes insert one bubble per cycle; the counter increments each cycle.
- Reset asserted mid-hold or mid-flush: reset wins at that edge.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_AW`
  - constant `REG_ZERO` = 5'd0
  - packed struct `mem_ctrl_t` {valid, wreg, m2reg, wmem, beq, bne, z}, so that MEM/WB can reuse the bundle.
- One sub-module: `pipe_reg`, a parameterised-width flop with sync active-low reset, enable (`!hold`) and clear (`flush`). It is instantiated for the control bundle, the data and the register number.
- The dependence compare and the bubble counter stay in the top level.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with random inputs → every output is 0, including `bubble_cnt`=0.
- Advance: `e_alu`=0x0000_0010, `e_b`=0x0000_0007, `e_rn`=5, `e_wreg`=1 → next cycle `m_alu`=0x10, `m_b`=7, `m_rn`=5, `m_wreg`=1, `m_valid`=1.
- Load→store dependence:
  - Case 1: a load to r8 is in MEM while the EX store has `e_rt`=8 → after the edge, `m_ldst_depen`=1.
  - Case 2: repeat with `e_rt`=9 → 0.
  - Case 3: repeat with the load targeting r0 and `e_rt`=0 → 0.
- Flush: `flush`=1 for 1 cycle with a valid store in EX → `m_wmem`=0, `m_valid`=0, `m_alu`=0, `bubble_cnt`=1.
- Hold vs flush: `hold`=1 and `flush`=1 for 3 cycles, then `flush` alone for 1 cycle → outputs unchanged for the 3 cycles, then a bubble is inserted and `bubble_cnt` increments by exactly 1.
- Saturation: with `CNT_W`=4, assert 20 flushes → `bubble_cnt`=15 and stays at 15.
